// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: latches fetched instruction, decodes it into the ID/EX register,
// detects load-use hazards and jumps. Latency: ins at edge N reaches id_* at edge N+1.
// Backpressure: a load-use hazard raises Stall/Stall_pm for one cycle and inserts a bubble.
//
// Ports:
//   clk, reset (async, active-low)
//   ins[23:0], Current_Address[7:0]  : fetched instruction and its address
//   jmp_loc[7:0], pc_mux_sel         : jump redirect to upstream PC mux
//   Stall, Stall_pm                  : hold upstream PC / instruction memory output
//   id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_pc, id_valid : registered decode
//   id_state[1:0]                    : FSM state (00 RUN, 01 HAZ, 10 FLUSH)
//   stall_count[15:0]                : saturating hazard counter, only with IF_ID_STALL_CNT_EN
module if_id_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] ins,
   input  logic [7:0]  Current_Address,
   output logic [7:0]  jmp_loc,
   output logic        pc_mux_sel,
   output logic        Stall,
   output logic        Stall_pm,
   output logic [4:0]  id_opcode,
   output logic [2:0]  id_rd,
   output logic [2:0]  id_rs1,
   output logic [2:0]  id_rs2,
   output logic [7:0]  id_imm,
   output logic [7:0]  id_pc,
   output logic        id_valid,
   output logic [1:0]  id_state
`ifdef IF_ID_STALL_CNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   localparam logic [4:0] OP_JMP  = 5'b11000;
   localparam logic [4:0] OP_LOAD = 5'b10100;

   typedef struct packed {
      logic [4:0] opcode;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [1:0] rsvd;
      logic [7:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_HAZ   = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   instr_t     ir;
   logic [7:0] ir_pc;
   logic       ir_valid;
   logic       hazard;
   logic       jump;
   state_t     state_q;
   state_t     state_d;

   // Reserved field is carried in the IF/ID register but never decoded.
   logic [1:0] unused_rsvd;
   assign unused_rsvd = ir.rsvd;

   // Load-use: the load in ID/EX writes a register that the instruction in IF/ID reads.
   assign hazard = ir_valid & id_valid & (id_opcode == OP_LOAD) &
                   ((id_rd == ir.rs1) | (id_rd == ir.rs2));

   // A stalled jump waits; it redirects the PC once the hazard bubble has been issued.
   assign jump = ir_valid & (ir.opcode == OP_JMP) & ~hazard;

   assign pc_mux_sel = jump;
   assign jmp_loc    = ir_valid ? ir.imm : 8'h00;
   assign Stall      = hazard;
   assign Stall_pm   = hazard;

   // IF/ID and ID/EX registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir        <= '0;
         ir_pc     <= 8'h00;
         ir_valid  <= 1'b0;
         id_opcode <= 5'h00;
         id_rd     <= 3'd0;
         id_rs1    <= 3'd0;
         id_rs2    <= 3'd0;
         id_imm    <= 8'h00;
         id_pc     <= 8'h00;
         id_valid  <= 1'b0;
      end else if (hazard) begin
         // Hold IF/ID, push a bubble into ID/EX; decoded fields keep their values.
         id_valid <= 1'b0;
      end else begin
         ir        <= ins;
         ir_pc     <= Current_Address;
         // The word fetched alongside a taken jump is the fall-through; squash it.
         ir_valid  <= ~jump;
         id_opcode <= ir.opcode;
         id_rd     <= ir.rd;
         id_rs1    <= ir.rs1;
         id_rs2    <= ir.rs2;
         id_imm    <= ir.imm;
         id_pc     <= ir_pc;
         id_valid  <= ir_valid;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = ST_RUN;
      if (hazard) begin
         state_d = ST_HAZ;
      end else if (jump) begin
         state_d = ST_FLUSH;
      end
   end

   // FSM: outputs
   always_comb begin
      id_state = state_q;
   end

`ifdef IF_ID_STALL_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= 16'h0000;
      end else if (hazard && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

   localparam logic [4:0] OP_JMP  = 5'b11000;
   localparam logic [4:0] OP_LOAD = 5'b10100;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] ins;
   logic [7:0]  Current_Address;
   logic [7:0]  jmp_loc;
   logic        pc_mux_sel;
   logic        Stall;
   logic        Stall_pm;
   logic [4:0]  id_opcode;
   logic [2:0]  id_rd;
   logic [2:0]  id_rs1;
   logic [2:0]  id_rs2;
   logic [7:0]  id_imm;
   logic [7:0]  id_pc;
   logic        id_valid;
   logic [1:0]  id_state;
`ifdef IF_ID_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   always #5 clk = ~clk;

   if_id_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ins             (ins),
      .Current_Address (Current_Address),
      .jmp_loc         (jmp_loc),
      .pc_mux_sel      (pc_mux_sel),
      .Stall           (Stall),
      .Stall_pm        (Stall_pm),
      .id_opcode       (id_opcode),
      .id_rd           (id_rd),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_imm          (id_imm),
      .id_pc           (id_pc),
      .id_valid        (id_valid),
      .id_state        (id_state)
`ifdef IF_ID_STALL_CNT_EN
      ,
      .stall_count     (stall_count)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Every output of the stage, in one bundle.
   function automatic logic [63:0] obs();
      return {20'h0, id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_pc,
              Stall, Stall_pm, pc_mux_sel, jmp_loc, id_state};
   endfunction

   // One clock: drive at falling edge, return 1 time unit after the rising edge.
   task automatic cycle(input logic r, input logic [23:0] i, input logic [7:0] a);
      @(negedge clk);
      reset           = r;
      ins             = i;
      Current_Address = a;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Two instruction slots: "fetched" (waiting for decode) and "decoded" (seen by execute).
   logic        f_v;
   logic [23:0] f_ins;
   logic [7:0]  f_pc;
   logic        d_v;
   logic [23:0] d_ins;
   logic [7:0]  d_pc;
   logic [1:0]  m_state;
   int          m_cnt;

   function automatic logic m_hazard();
      return f_v && d_v && (d_ins[23:19] == OP_LOAD) &&
             ((d_ins[18:16] == f_ins[15:13]) || (d_ins[18:16] == f_ins[12:10]));
   endfunction

   function automatic logic m_jump();
      return f_v && (f_ins[23:19] == OP_JMP) && !m_hazard();
   endfunction

   task automatic m_step(input logic r, input logic [23:0] i, input logic [7:0] a);
      logic hz;
      logic jp;
      if (!r) begin
         f_v = 0; f_ins = '0; f_pc = '0;
         d_v = 0; d_ins = '0; d_pc = '0;
         m_state = 2'b00; m_cnt = 0;
      end else begin
         hz = m_hazard();
         jp = m_jump();
         if (hz) begin
            d_v     = 0;
            m_state = 2'b01;
            if (m_cnt < 65535) m_cnt++;
         end else begin
            d_v     = f_v;
            d_ins   = f_ins;
            d_pc    = f_pc;
            f_v     = !jp;
            f_ins   = i;
            f_pc    = a;
            m_state = jp ? 2'b10 : 2'b00;
         end
      end
   endtask

   function automatic logic [63:0] m_obs();
      logic hz;
      hz = m_hazard();
      return {20'h0, d_v, d_ins[23:19], d_ins[18:16], d_ins[15:13], d_ins[12:10], d_ins[7:0],
              d_pc, hz, hz, m_jump(), (f_v ? f_ins[7:0] : 8'h00), m_state};
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst_n;
      logic [23:0] ins;
      logic [7:0]  addr;
      logic        e_valid;
      logic [4:0]  e_op;
      logic [2:0]  e_rd;
      logic [7:0]  e_pc;
      logic        e_stall;
      logic        e_pcsel;
      logic [7:0]  e_jloc;
      logic [1:0]  e_state;
   } vec_t;

   vec_t tbl[13];

   // Bring a hazard or jump up, then abort it with an asynchronous mid-cycle reset.
   task automatic abort_test(input string name, input logic [23:0] a, input logic [23:0] b,
                             input logic want_stall);
      cycle(1'b0, 24'h0, 8'h00);
      cycle(1'b1, a, 8'h10);
      cycle(1'b1, b, 8'h11);
      check({name, "_pre"}, {63'h0, (want_stall ? Stall : pc_mux_sel)}, 64'h1);
      #2 reset = 1'b0;
      #1 check({name, "_async_clear"}, obs(), 64'h0);
      cycle(1'b1, 24'h08_2400, 8'h30);
      cycle(1'b1, 24'h00_0000, 8'h31);
      check({name, "_restart"}, {51'h0, id_valid, id_opcode, id_pc, Stall, pc_mux_sel, id_state},
            {51'h0, 1'b1, 5'h01, 8'h30, 1'b0, 1'b0, 2'b00});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [23:0] r_ins;
      logic        r_rst;
      int          sel;

      reset = 1'b0;
      ins = 24'h0;
      Current_Address = 8'h00;

      //          rst ins           addr   vld op     rd    pc     stl pcs jloc   st
      tbl[0]  = '{0, 24'hFF_FFFF, 8'hFF, 0, 5'h00, 3'd0, 8'h00, 0, 0, 8'h00, 2'b00};
      tbl[1]  = '{0, 24'hFF_FFFF, 8'hFF, 0, 5'h00, 3'd0, 8'h00, 0, 0, 8'h00, 2'b00};
      tbl[2]  = '{1, 24'h08_2400, 8'h00, 0, 5'h00, 3'd0, 8'h00, 0, 0, 8'h00, 2'b00};
      tbl[3]  = '{1, 24'hA3_0000, 8'h01, 1, 5'h01, 3'd0, 8'h00, 0, 0, 8'h00, 2'b00};
      tbl[4]  = '{1, 24'h08_6000, 8'h02, 1, 5'h14, 3'd3, 8'h01, 1, 0, 8'h00, 2'b00};
      tbl[5]  = '{1, 24'h00_0000, 8'h03, 0, 5'h14, 3'd3, 8'h01, 0, 0, 8'h00, 2'b01};
      tbl[6]  = '{1, 24'hC0_0008, 8'h03, 1, 5'h01, 3'd0, 8'h02, 0, 1, 8'h08, 2'b00};
      tbl[7]  = '{1, 24'h00_0000, 8'h04, 1, 5'h18, 3'd0, 8'h03, 0, 0, 8'h00, 2'b10};
      tbl[8]  = '{1, 24'hA2_0000, 8'h08, 0, 5'h00, 3'd0, 8'h04, 0, 0, 8'h00, 2'b00};
      tbl[9]  = '{1, 24'hC0_0810, 8'h09, 1, 5'h14, 3'd2, 8'h08, 1, 0, 8'h10, 2'b00};
      tbl[10] = '{1, 24'h00_0000, 8'h0A, 0, 5'h14, 3'd2, 8'h08, 0, 1, 8'h10, 2'b01};
      tbl[11] = '{1, 24'h00_0000, 8'h0A, 1, 5'h18, 3'd0, 8'h09, 0, 0, 8'h00, 2'b10};
      tbl[12] = '{1, 24'h00_0000, 8'h10, 0, 5'h00, 3'd0, 8'h0A, 0, 0, 8'h00, 2'b00};

      for (int k = 0; k < 13; k++) begin
         cycle(tbl[k].rst_n, tbl[k].ins, tbl[k].addr);
         check($sformatf("table[%0d]", k),
               {34'h0, id_valid, id_opcode, id_rd, id_pc, Stall, Stall_pm, pc_mux_sel, jmp_loc, id_state},
               {34'h0, tbl[k].e_valid, tbl[k].e_op, tbl[k].e_rd, tbl[k].e_pc, tbl[k].e_stall,
                tbl[k].e_stall, tbl[k].e_pcsel, tbl[k].e_jloc, tbl[k].e_state});
         if (!tbl[k].rst_n)
            check($sformatf("table[%0d]_reset_fields", k), {50'h0, id_rs1, id_rs2, id_imm}, 64'h0);
      end

      abort_test("abort_stall", 24'hA3_0000, 24'h08_6000, 1'b1);
      abort_test("abort_flush", 24'h00_0000, 24'hC0_0008, 1'b0);

`ifdef IF_ID_STALL_CNT_EN
      cycle(1'b0, 24'h0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 24'hA3_0000, 8'h00);
         cycle(1'b1, 24'h08_6000, 8'h01);
         cycle(1'b1, 24'h00_0000, 8'h02);
         cycle(1'b1, 24'h00_0000, 8'h03);
      end
      check("stall_count_three", {48'h0, stall_count}, 64'd3);
      #2 reset = 1'b0;
      #1 check("stall_count_reset", {48'h0, stall_count}, 64'd0);
`endif

      // Randomized run against the model; registers and opcodes biased toward hazards/jumps.
      for (int n = 0; n < 600; n++) begin
         r_rst = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
         sel   = $urandom_range(0, 3);
         r_ins = 24'($urandom);
         if (sel == 0) r_ins[23:19] = OP_LOAD;
         if (sel == 1) r_ins[23:19] = OP_JMP;
         r_ins[18:16] = 3'($urandom_range(0, 3));
         r_ins[15:13] = 3'($urandom_range(0, 3));
         r_ins[12:10] = 3'($urandom_range(0, 3));
         m_step(r_rst, r_ins, 8'(n));
         cycle(r_rst, r_ins, 8'(n));
         check($sformatf("random[%0d]", n), obs(), m_obs());
`ifdef IF_ID_STALL_CNT_EN
         check($sformatf("random_cnt[%0d]", n), {48'h0, stall_count}, 64'(m_cnt));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
